// File: rtl/fp_word_serializer_pkg.sv
// rtl/fp_word_serializer_pkg.sv - shared constants for the fp32 word serializer
package fp_word_serializer_pkg;

  // Word size and lane count of the upstream pair-adder bus.
  localparam int FP_WIDTH  = 32;
  localparam int BUS_LANES = 16;

  // Lane order: lane 0 is the most significant word of a beat, so the
  // serializer always emits the top word and shifts the beat left.

  // Serializer state encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/fp_word_serializer_beat_fifo.sv
// rtl/fp_word_serializer_beat_fifo.sv - small synchronous beat FIFO with level count
module beat_fifo
  import fp_word_serializer_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH * BUS_LANES + 1,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against pushing into a full FIFO or popping an empty one.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fp_word_serializer.sv
// rtl/fp_word_serializer.sv - buffers 16-lane fp32 beats and streams them one word per cycle
module fp_word_serializer
  import fp_word_serializer_pkg::*;
#(
  parameter int LANES = BUS_LANES,
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [LANES*WIDTH-1:0]     in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_sol,
  output logic                       out_eol,
  output logic [$clog2(LANES)-1:0]   out_lane,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int BW = LANES * WIDTH;
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [0:0]    state;
  logic [BW-1:0] shreg;
  logic [LW-1:0] lane;
  logic          cur_last;
  logic          sol_pending;

  logic          fifo_full;
  logic          fifo_empty;
  logic [BW:0]   fifo_rdata;
  logic          push;
  logic          pop;
  logic          hs;
  logic          load;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  assign out_valid = (state == ST_SHIFT);
  assign out_data  = shreg[BW-1 -: WIDTH];
  assign out_lane  = lane;
  assign out_sol   = out_valid && (lane == '0) && sol_pending;
  assign out_eol   = out_valid && (lane == LAST_LANE) && cur_last;

  assign hs = out_valid && out_ready;

  // A new beat is taken when idle, or straight after the last lane handshakes
  // so consecutive beats stream without a bubble.
  assign load = !fifo_empty && ((state == ST_IDLE) || (hs && (lane == LAST_LANE)));
  assign pop  = load;

  beat_fifo #(
    .WIDTH (BW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push),
    .wdata ({in_last, in_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Serializer FSM: load a beat, walk its lanes on each handshake, return to idle when starved.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      lane     <= '0;
      cur_last <= 1'b0;
    end else if (load) begin
      state    <= ST_SHIFT;
      shreg    <= fifo_rdata[BW-1:0];
      cur_last <= fifo_rdata[BW];
      lane     <= '0;
    end else if (hs) begin
      if (lane == LAST_LANE) begin
        state <= ST_IDLE;
      end else begin
        lane  <= lane + 1'b1;
        shreg <= {shreg[BW-WIDTH-1:0], {WIDTH{1'b0}}};
      end
    end
  end

  // Line markers: a line starts after reset or after a word flagged end-of-line.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sol_pending <= 1'b1;
    end else if (hs && out_eol) begin
      sol_pending <= 1'b1;
    end else if (hs && out_sol) begin
      sol_pending <= 1'b0;
    end
  end

  // Upstream cannot stall, so a beat offered while full is lost and remembered until reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_word_serializer.sv
// tb/tb_fp_word_serializer.sv - self-checking bench for fp_word_serializer
module tb_fp_word_serializer;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [511:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_sol;
  logic         out_eol;
  logic [3:0]   out_lane;
  logic         overflow;
  logic [2:0]   fifo_level;

  fp_word_serializer dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .out_lane   (out_lane),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          lane;
    bit          sol;
    bit          eol;
  } word_t;

  word_t exp_q[$];
  bit    line_start = 1'b1;
  int    n_checks = 0;
  int    n_pass = 0;
  int    hs_count = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic make_beat(input logic [31:0] base, output logic [511:0] b);
    for (int k = 0; k < 16; k++) begin
      b[511 - 32*k -: 32] = base + 32'(k);
    end
  endtask

  task automatic rand_beat(output logic [511:0] b);
    for (int k = 0; k < 16; k++) begin
      b[511 - 32*k -: 32] = $urandom;
    end
  endtask

  // Reference: an accepted beat becomes 16 words, lane 0 = top word.
  task automatic model_push(input logic [511:0] b, input bit last);
    word_t w;
    for (int k = 0; k < 16; k++) begin
      w.data = b[511 - 32*k -: 32];
      w.lane = k;
      w.sol  = (k == 0) && line_start;
      w.eol  = (k == 15) && last;
      exp_q.push_back(w);
    end
    line_start = last;
  endtask

  task automatic drive_beat(input logic [511:0] b, input bit last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
  endtask

  task automatic reset_dut;
    Reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    line_start = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick;
      n++;
    end
    check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard every handshake and check hold behaviour while stalled.
  initial begin
    word_t       e;
    bit          prev_stall;
    logic [31:0] p_data;
    logic [3:0]  p_lane;
    logic        p_sol;
    logic        p_eol;
    prev_stall = 1'b0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 64'(out_valid), 64'd1);
          check_eq("hold_data", 64'(out_data), 64'(p_data));
          check_eq("hold_lane", 64'(out_lane), 64'(p_lane));
          check_eq("hold_sol", 64'(out_sol), 64'(p_sol));
          check_eq("hold_eol", 64'(out_eol), 64'(p_eol));
        end
        if (out_valid && out_ready) begin
          check_eq("word_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("word_data", 64'(out_data), 64'(e.data));
            check_eq("word_lane", 64'(out_lane), 64'(e.lane));
            check_eq("word_sol", 64'(out_sol), 64'(e.sol));
            check_eq("word_eol", 64'(out_eol), 64'(e.eol));
          end
          hs_count++;
        end
        prev_stall = out_valid && !out_ready;
        p_data = out_data;
        p_lane = out_lane;
        p_sol  = out_sol;
        p_eol  = out_eol;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [511:0] b;
    int first;
    int lastc;
    int cnt;
    int base;
    int pat[4];
    bit lst;

    // Reset values
    reset_dut();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_sol", 64'(out_sol), 64'd0);
    check_eq("rst_out_eol", 64'(out_eol), 64'd0);
    check_eq("rst_out_lane", 64'(out_lane), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_level", 64'(fifo_level), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Single-beat line: latency t+2, 16 contiguous words then idle
    out_ready = 1'b1;
    first = -1; lastc = -1; cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) begin
        make_beat(32'h3F80_0000, b);
        drive_beat(b, 1'b1);
        model_push(b, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        cnt++;
        if (first < 0) first = cyc;
        lastc = cyc;
        if (cyc == 2) check_eq("single_lane0_data", 64'(out_data), 64'h3F80_0000);
      end
      tick;
    end
    check_eq("single_first_cycle", 64'(first), 64'd2);
    check_eq("single_word_count", 64'(cnt), 64'd16);
    check_eq("single_last_cycle", 64'(lastc), 64'd17);
    wait_drain("single");

    // Back-to-back: lines of 3 beats (last=0,0,1) and 1 beat, no bubbles
    first = -1; lastc = -1; cnt = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc < 4) begin
        check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
        make_beat(32'h3F80_0000 + 32'(16 * cyc), b);
        lst = (cyc >= 2);
        drive_beat(b, lst);
        model_push(b, lst);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        cnt++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      tick;
    end
    check_eq("b2b_first_cycle", 64'(first), 64'd2);
    check_eq("b2b_word_count", 64'(cnt), 64'd64);
    check_eq("b2b_last_cycle", 64'(lastc), 64'd65);
    wait_drain("b2b");

    // Backpressure: out_ready pattern 1,0,0,1
    pat = '{1, 0, 0, 1};
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 0) begin
        make_beat(32'hC000_0100, b);
        drive_beat(b, 1'b1);
        model_push(b, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (pat[cyc % 4] != 0);
      tick;
    end
    out_ready = 1'b1;
    wait_drain("bp");

    // Full FIFO with a pop on the same cycle as an offered beat
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      make_beat(32'h1000_0000 + 32'(256 * i), b);
      drive_beat(b, 1'b1);
      model_push(b, 1'b1);
      tick;
    end
    in_valid = 1'b0;
    check_eq("fullpop_level4", 64'(fifo_level), 64'd4);
    check_eq("fullpop_not_ready", 64'(in_ready), 64'd0);
    check_eq("fullpop_lane0", 64'(out_lane), 64'd0);
    out_ready = 1'b1;
    repeat (15) tick;
    check_eq("fullpop_lane15", 64'(out_lane), 64'd15);
    make_beat(32'hDEAD_0000, b);
    drive_beat(b, 1'b1);
    tick;
    out_ready = 1'b0;
    make_beat(32'hBEEF_0000, b);
    drive_beat(b, 1'b1);
    check_eq("fullpop_ready_again", 64'(in_ready), 64'd1);
    check_eq("fullpop_level3", 64'(fifo_level), 64'd3);
    check_eq("fullpop_overflow", 64'(overflow), 64'd1);
    check_eq("fullpop_next_lane0", 64'(out_lane), 64'd0);
    model_push(b, 1'b1);
    tick;
    in_valid = 1'b0;
    check_eq("fullpop_level_back4", 64'(fifo_level), 64'd4);
    check_eq("fullpop_full_again", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain("fullpop");

    // Overflow: stalled output, six beats offered; first one moves into the
    // serializer, four fill the FIFO, the sixth is dropped
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check_eq("ovf_level_before", 64'(fifo_level), 64'd4);
        check_eq("ovf_in_ready_before", 64'(in_ready), 64'd0);
        check_eq("ovf_flag_before", 64'(overflow), 64'd0);
      end
      make_beat(32'h2000_0000 + 32'(256 * i), b);
      drive_beat(b, 1'b1);
      if (i < 5) model_push(b, 1'b1);
      tick;
    end
    in_valid = 1'b0;
    check_eq("ovf_flag_set", 64'(overflow), 64'd1);
    check_eq("ovf_level_after", 64'(fifo_level), 64'd4);
    out_ready = 1'b1;
    wait_drain("ovf");
    tick;
    check_eq("ovf_idle_valid", 64'(out_valid), 64'd0);
    check_eq("ovf_level_empty", 64'(fifo_level), 64'd0);
    check_eq("ovf_flag_sticky", 64'(overflow), 64'd1);

    // Reset at lane 7 of beat 2 of a 3-beat line
    base = hs_count;
    for (int i = 0; i < 3; i++) begin
      make_beat(32'h3000_0000 + 32'(256 * i), b);
      drive_beat(b, i == 2);
      model_push(b, i == 2);
      tick;
    end
    in_valid = 1'b0;
    cnt = 0;
    while (hs_count < base + 23 && cnt < 200) begin
      tick;
      cnt++;
    end
    check_eq("midrst_reached_lane7", 64'(out_lane), 64'd7);
    Reset = 1'b1;
    exp_q.delete();
    line_start = 1'b1;
    tick;
    Reset = 1'b0;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_level", 64'(fifo_level), 64'd0);
    check_eq("midrst_overflow", 64'(overflow), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    make_beat(32'h4000_0000, b);
    drive_beat(b, 1'b0);
    model_push(b, 1'b0);
    tick;
    in_valid = 1'b0;
    check_eq("midrst_t1_valid", 64'(out_valid), 64'd0);
    tick;
    check_eq("midrst_t2_valid", 64'(out_valid), 64'd1);
    check_eq("midrst_t2_sol", 64'(out_sol), 64'd1);
    check_eq("midrst_t2_lane", 64'(out_lane), 64'd0);
    wait_drain("midrst");

    // Randomized traffic with random backpressure; pushes only while room is guaranteed
    for (int cyc = 0; cyc < 600; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (exp_q.size() <= 48 && $urandom_range(0, 2) == 0) begin
        check_eq("rand_in_ready", 64'(in_ready), 64'd1);
        rand_beat(b);
        lst = ($urandom_range(0, 1) == 1);
        drive_beat(b, lst);
        model_push(b, lst);
      end else begin
        in_valid = 1'b0;
      end
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand");
    check_eq("rand_no_overflow", 64'(overflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
